// File: rtl/softex_row_acc_ctrl.sv
// Job sequencer for the SoftEx row accumulator: clears the accumulator, meters len
// weight/operand transfers with a row strobe, then forwards the single result beat.
module softex_row_acc_ctrl #(
  parameter  int NUM_ROWS   = 4,
  parameter  int LEN_WIDTH  = 16,
  localparam int ROWS_WIDTH = $clog2(NUM_ROWS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [ROWS_WIDTH-1:0] active_rows_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  count_o,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  output logic                  acc_weight_valid_o,
  input  logic                  acc_weight_ready_i,
  output logic                  acc_op_valid_o,
  input  logic                  acc_op_ready_i,
  output logic                  acc_last_weight_o,
  output logic [NUM_ROWS-1:0]   acc_strb_o,
  output logic                  acc_clear_o,
  input  logic                  acc_valid_i,
  output logic                  acc_ready_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  next_state;
  logic [LEN_WIDTH-1:0]    count;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [ROWS_WIDTH-1:0]   rows_q;
  logic [ROWS_WIDTH-1:0]   rows_clamped;
  logic [NUM_ROWS-1:0]     rows_mask;
  logic                    at_last;
  logic                    xfer;

  // Requests for more rows than physically exist saturate to the full array.
  assign rows_clamped = (active_rows_i > ROWS_WIDTH'(NUM_ROWS)) ? ROWS_WIDTH'(NUM_ROWS)
                                                                : active_rows_i;
  assign at_last      = (count == len_q - LEN_WIDTH'(1));
  assign count_o      = count;

  always_comb begin
    rows_mask = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      rows_mask[i] = (ROWS_WIDTH'(i) < rows_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      count  <= '0;
      len_q  <= '0;
      rows_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start_i) begin
        len_q  <= len_i;
        rows_q <= rows_clamped;
        if (next_state == CLEAR) begin
          count <= '0;
        end
      end else if (state == CLEAR) begin
        count <= '0;
      end else if (xfer) begin
        count <= count + LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    next_state         = state;
    busy_o             = (state != IDLE);
    done_o             = 1'b0;
    w_ready_o          = 1'b0;
    op_ready_o         = 1'b0;
    acc_weight_valid_o = 1'b0;
    acc_op_valid_o     = 1'b0;
    acc_last_weight_o  = 1'b0;
    acc_strb_o         = '0;
    acc_clear_o        = 1'b0;
    acc_ready_o        = 1'b0;
    res_valid_o        = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          next_state = (len_i == '0 || rows_clamped == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        acc_clear_o = 1'b1;
        next_state  = STREAM;
      end
      STREAM: begin
        acc_weight_valid_o = w_valid_i;
        acc_op_valid_o     = op_valid_i;
        w_ready_o          = acc_weight_ready_i;
        op_ready_o         = acc_op_ready_i;
        acc_last_weight_o  = at_last;
        acc_strb_o         = rows_mask;
        if (w_valid_i && acc_weight_ready_i && at_last) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        res_valid_o = acc_valid_i;
        acc_ready_o = res_ready_i;
        if (acc_valid_i && res_ready_i) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Abort wins over every transition and silences all handshakes for that cycle.
    if (abort_i && state != IDLE) begin
      next_state         = IDLE;
      acc_clear_o        = 1'b1;
      done_o             = 1'b0;
      w_ready_o          = 1'b0;
      op_ready_o         = 1'b0;
      acc_weight_valid_o = 1'b0;
      acc_op_valid_o     = 1'b0;
      acc_last_weight_o  = 1'b0;
      acc_strb_o         = '0;
      acc_ready_o        = 1'b0;
      res_valid_o        = 1'b0;
    end
    xfer = acc_weight_valid_o & acc_weight_ready_i;
  end

endmodule

// File: tb/tb_softex_row_acc_ctrl.sv
// Directed bench for softex_row_acc_ctrl: hand-computed expectations for normal jobs,
// empty jobs, abort, result back-pressure and asynchronous reset.
module tb_softex_row_acc_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [15:0] len_i;
  logic [2:0]  active_rows_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] count_o;
  logic        w_valid_i;
  logic        w_ready_o;
  logic        op_valid_i;
  logic        op_ready_o;
  logic        acc_weight_valid_o;
  logic        acc_weight_ready_i;
  logic        acc_op_valid_o;
  logic        acc_op_ready_i;
  logic        acc_last_weight_o;
  logic [3:0]  acc_strb_o;
  logic        acc_clear_o;
  logic        acc_valid_i;
  logic        acc_ready_o;
  logic        res_valid_o;
  logic        res_ready_i;

  int checks;
  int errors;

  softex_row_acc_ctrl #(.NUM_ROWS(4), .LEN_WIDTH(16)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .start_i            (start_i),
    .abort_i            (abort_i),
    .len_i              (len_i),
    .active_rows_i      (active_rows_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .count_o            (count_o),
    .w_valid_i          (w_valid_i),
    .w_ready_o          (w_ready_o),
    .op_valid_i         (op_valid_i),
    .op_ready_o         (op_ready_o),
    .acc_weight_valid_o (acc_weight_valid_o),
    .acc_weight_ready_i (acc_weight_ready_i),
    .acc_op_valid_o     (acc_op_valid_o),
    .acc_op_ready_i     (acc_op_ready_i),
    .acc_last_weight_o  (acc_last_weight_o),
    .acc_strb_o         (acc_strb_o),
    .acc_clear_o        (acc_clear_o),
    .acc_valid_i        (acc_valid_i),
    .acc_ready_o        (acc_ready_o),
    .res_valid_o        (res_valid_o),
    .res_ready_i        (res_ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic abort,
                               input logic [15:0] len, input logic [2:0] rows);
    start_i       = start;
    abort_i       = abort;
    len_i         = len;
    active_rows_i = rows;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Drives a result beat through DRAIN and checks the DONE pulse and return to IDLE.
  task automatic finishJob(input int expCount);
    acc_valid_i = 1'b1;
    res_ready_i = 1'b1;
    #1;
    checkOutput("drain_res_valid", 32'(res_valid_o), 1);
    checkOutput("drain_acc_ready", 32'(acc_ready_o), 1);
    checkOutput("drain_no_done", 32'(done_o), 0);
    nextCycle();
    acc_valid_i = 1'b0;
    #1;
    checkOutput("done_pulse", 32'(done_o), 1);
    checkOutput("done_busy", 32'(busy_o), 1);
    checkOutput("done_count", 32'(count_o), 32'(expCount));
    nextCycle();
    #1;
    checkOutput("idle_done_low", 32'(done_o), 0);
    checkOutput("idle_busy_low", 32'(busy_o), 0);
    checkOutput("idle_count_hold", 32'(count_o), 32'(expCount));
  endtask

  initial begin
    int cnt;
    logic [4:0] pattern;
    checks = 0;
    errors = 0;
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'd0, 3'd0);
    w_valid_i = 1'b0;
    op_valid_i = 1'b0;
    acc_weight_ready_i = 1'b0;
    acc_op_ready_i = 1'b0;
    acc_valid_i = 1'b0;
    res_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(busy_o), 0);
    checkOutput("reset_count", 32'(count_o), 0);
    checkOutput("reset_clear", 32'(acc_clear_o), 0);
    checkOutput("reset_strb", 32'(acc_strb_o), 0);

    // Job 1: len=4, rows=4, sources always valid, accumulator always ready.
    nextCycle();
    w_valid_i = 1'b1;
    op_valid_i = 1'b1;
    acc_weight_ready_i = 1'b1;
    acc_op_ready_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'd4, 3'd4);
    #1;
    checkOutput("j1_idle_no_fwd", 32'(acc_weight_valid_o), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 16'd4, 3'd4);
    #1;
    checkOutput("j1_clear", 32'(acc_clear_o), 1);
    checkOutput("j1_clear_count", 32'(count_o), 0);
    checkOutput("j1_clear_no_fwd", 32'(acc_weight_valid_o), 0);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("j1_wvalid", 32'(acc_weight_valid_o), 1);
      checkOutput("j1_opvalid", 32'(acc_op_valid_o), 1);
      checkOutput("j1_wready", 32'(w_ready_o), 1);
      checkOutput("j1_strb", 32'(acc_strb_o), 15);
      checkOutput("j1_last", 32'(acc_last_weight_o), 32'(k == 3));
      checkOutput("j1_count", 32'(count_o), 32'(k));
      checkOutput("j1_no_clear", 32'(acc_clear_o), 0);
      nextCycle();
    end
    #1;
    checkOutput("j1_drain_wvalid", 32'(acc_weight_valid_o), 0);
    checkOutput("j1_drain_wready", 32'(w_ready_o), 0);
    checkOutput("j1_drain_count", 32'(count_o), 4);
    checkOutput("j1_drain_idle_res", 32'(res_valid_o), 0);
    finishJob(4);

    // Job 2: len=3, rows=2, both sources toggling 1,0,1,0,1.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'd3, 3'd2);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 16'd3, 3'd2);
    nextCycle();
    pattern = 5'b10101;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      w_valid_i = pattern[k];
      op_valid_i = pattern[k];
      #1;
      checkOutput("j2_strb", 32'(acc_strb_o), 3);
      checkOutput("j2_count", 32'(count_o), 32'(cnt));
      checkOutput("j2_wvalid", 32'(acc_weight_valid_o), 32'(pattern[k]));
      checkOutput("j2_last", 32'(acc_last_weight_o), 32'(cnt == 2));
      if (pattern[k]) cnt++;
      nextCycle();
    end
    w_valid_i = 1'b1;
    op_valid_i = 1'b1;
    #1;
    checkOutput("j2_drain_count", 32'(count_o), 3);
    checkOutput("j2_drain_strb", 32'(acc_strb_o), 0);
    checkOutput("j2_drain_wvalid", 32'(acc_weight_valid_o), 0);
    finishJob(3);

    // Empty jobs: len=0, then rows=0; straight to DONE without a clear.
    for (int e = 0; e < 2; e++) begin
      nextCycle();
      if (e == 0) applyStimulus(1'b1, 1'b0, 16'd0, 3'd4);
      else        applyStimulus(1'b1, 1'b0, 16'd5, 3'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'd0, 3'd0);
      #1;
      checkOutput("empty_done", 32'(done_o), 1);
      checkOutput("empty_no_clear", 32'(acc_clear_o), 0);
      checkOutput("empty_no_wvalid", 32'(acc_weight_valid_o), 0);
      nextCycle();
      #1;
      checkOutput("empty_idle", 32'(busy_o), 0);
      checkOutput("empty_done_low", 32'(done_o), 0);
      checkOutput("empty_no_clear2", 32'(acc_clear_o), 0);
    end

    // Abort after 2 of 5 transfers, then a clean 5-element job.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'd5, 3'd4);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 16'd5, 3'd4);
    nextCycle();
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b1, 16'd5, 3'd4);
    #1;
    checkOutput("abort_count", 32'(count_o), 2);
    checkOutput("abort_clear", 32'(acc_clear_o), 1);
    checkOutput("abort_wvalid", 32'(acc_weight_valid_o), 0);
    checkOutput("abort_wready", 32'(w_ready_o), 0);
    checkOutput("abort_opready", 32'(op_ready_o), 0);
    checkOutput("abort_no_done", 32'(done_o), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 16'd5, 3'd4);
    #1;
    checkOutput("abort_idle", 32'(busy_o), 0);
    checkOutput("abort_idle_done", 32'(done_o), 0);
    checkOutput("abort_idle_clear", 32'(acc_clear_o), 0);
    applyStimulus(1'b1, 1'b0, 16'd5, 3'd4);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 16'd5, 3'd4);
    #1;
    checkOutput("rerun_clear", 32'(acc_clear_o), 1);
    checkOutput("rerun_count0", 32'(count_o), 0);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("rerun_count", 32'(count_o), 32'(k));
      checkOutput("rerun_last", 32'(acc_last_weight_o), 32'(k == 4));
      nextCycle();
    end
    finishJob(5);

    // Result back-pressure in DRAIN with start_i asserted throughout.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'd2, 3'd1);
    nextCycle();
    nextCycle();
    #1;
    checkOutput("bp_strb", 32'(acc_strb_o), 1);
    nextCycle();
    nextCycle();
    acc_valid_i = 1'b1;
    res_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("bp_res_valid", 32'(res_valid_o), 1);
      checkOutput("bp_acc_ready", 32'(acc_ready_o), 0);
      checkOutput("bp_no_done", 32'(done_o), 0);
      checkOutput("bp_busy", 32'(busy_o), 1);
      checkOutput("bp_no_clear", 32'(acc_clear_o), 0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 16'd2, 3'd1);
    finishJob(2);
    #1;
    checkOutput("bp_idle_no_clear", 32'(acc_clear_o), 0);

    // Reset asserted mid-STREAM; rows=7 saturates to the full strobe.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'd5, 3'd7);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 16'd5, 3'd7);
    nextCycle();
    #1;
    checkOutput("sat_strb", 32'(acc_strb_o), 15);
    nextCycle();
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_wvalid", 32'(acc_weight_valid_o), 0);
    checkOutput("rst_strb", 32'(acc_strb_o), 0);
    checkOutput("rst_count", 32'(count_o), 0);
    checkOutput("rst_clear", 32'(acc_clear_o), 0);
    nextCycle();
    rst_i = 1'b0;
    nextCycle();
    #1;
    checkOutput("post_rst_idle", 32'(busy_o), 0);
    checkOutput("post_rst_wvalid", 32'(acc_weight_valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
